// File: rtl/fpu_pkg.sv
// Shared FPU types and default constants for the fmul result path.
// fmul_res_t is the writeback payload: destination tag, product and overflow flag.
package fpu_pkg;

  localparam int FMUL_NSTAGE = 2;
  localparam int FPU_TAGW    = 5;

  typedef struct packed {
    logic [FPU_TAGW-1:0] tag;
    logic [31:0]         y;
    logic                ovf;
  } fmul_res_t;

endpackage

// File: rtl/fpu_res_fifo.sv
// In-order circular result buffer, parameterised on depth (power of two) and payload type.
// Reads are registered-only: a push into an empty buffer shows on rdata the next cycle.
module fpu_res_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  T                               wdata,
  input  logic                           pop,
  output T                               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Empty buffer presents zeros so the head is clean out of reset.
  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fmul_wb.sv
// Result-collection stage behind the NSTAGE-deep fmul pipeline: tag alignment, credit flow control,
// in-order result FIFO and writeback handshake. Define FMUL_WB_STICKY_OVF_EN to build the sticky overflow flag.
module fmul_wb
  import fpu_pkg::*;
#(
  parameter int NSTAGE = FMUL_NSTAGE,
  parameter int DEPTH  = 4,
  parameter int TAGW   = FPU_TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [TAGW-1:0] issue_tag,
  output logic            issue_ready,
  input  logic [31:0]     fmul_y,
  input  logic            fmul_ovf,
  output logic            out_valid,
  output logic [TAGW-1:0] out_tag,
  output logic [31:0]     out_y,
  output logic            out_ovf,
  input  logic            out_ready,
  input  logic            ovf_clr,
  output logic            ovf_sticky
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [31:0]     y;
    logic            ovf;
  } res_t;

  // Handshake: a transfer happens on a rising edge where valid && ready; the source holds its
  // payload steady while valid && !ready, and ready never depends combinationally on valid.
  logic            accept;
  logic            push;
  logic            pop;
  logic [NSTAGE-1:0] pipe_v;
  logic [TAGW-1:0] pipe_tag [NSTAGE];
  logic [CW-1:0]   reserved;
  logic [CW-1:0]   res_count;
  res_t            wdata;
  res_t            head;

  assign accept = issue_valid && issue_ready;
  assign push   = pipe_v[NSTAGE-1];
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < NSTAGE; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= issue_tag;
    for (int i = 1; i < NSTAGE; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  // Credits cover both in-flight multiplies and buffered results, so a push never meets a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reserved <= '0;
    end else if (accept && !pop) begin
      reserved <= reserved + 1'b1;
    end else if (pop && !accept) begin
      reserved <= reserved - 1'b1;
    end
  end

  assign issue_ready = (reserved != FULL);

  assign wdata = '{tag: pipe_tag[NSTAGE-1], y: fmul_y, ovf: fmul_ovf};

  fpu_res_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .count (res_count)
  );

  assign out_valid = (res_count != '0);
  assign out_tag   = head.tag;
  assign out_y     = head.y;
  assign out_ovf   = head.ovf;

`ifdef FMUL_WB_STICKY_OVF_EN
  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (pop && out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_wb.sv
// Self-checking bench for fmul_wb: a behavioural fmul delay line, driver tasks, and a scoreboard
// whose monitor pops expected results whenever writeback takes the FIFO head.
module tb_fmul_wb;
  import fpu_pkg::*;

  localparam int NSTAGE = FMUL_NSTAGE;
  localparam int DEPTH  = 4;
  localparam int TAGW   = FPU_TAGW;
  localparam int W      = $bits(fmul_res_t);
`ifdef FMUL_WB_STICKY_OVF_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic [TAGW-1:0] issue_tag;
  logic            issue_ready;
  logic [31:0]     fmul_y;
  logic            fmul_ovf;
  logic            out_valid;
  logic [TAGW-1:0] out_tag;
  logic [31:0]     out_y;
  logic            out_ovf;
  logic            out_ready;
  logic            ovf_clr;
  logic            ovf_sticky;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] exp_q[$];
  int           pop_cyc_q[$];

  // Hand-computed IEEE-754 single products: 1*2, 1.5*2, 2*2, 3*0.5, -1*2, 0.5*0.5, 0*5, 1*1
  logic [31:0] vec_y [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3FC00000,
                             32'hC0000000, 32'h3E800000, 32'h00000000, 32'h3F800000};

  fmul_wb #(
    .NSTAGE (NSTAGE),
    .DEPTH  (DEPTH),
    .TAGW   (TAGW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .fmul_y      (fmul_y),
    .fmul_ovf    (fmul_ovf),
    .out_valid   (out_valid),
    .out_tag     (out_tag),
    .out_y       (out_y),
    .out_ovf     (out_ovf),
    .out_ready   (out_ready),
    .ovf_clr     (ovf_clr),
    .ovf_sticky  (ovf_sticky)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- fmul model: product emerges NSTAGE cycles after issue ----------------
  logic [31:0] op_y;
  logic        op_ovf;
  logic [31:0] fm_y   [NSTAGE];
  logic        fm_ovf [NSTAGE];

  always @(posedge clk) begin
    fm_y[0]   <= op_y;
    fm_ovf[0] <= op_ovf;
    for (int i = 1; i < NSTAGE; i++) begin
      fm_y[i]   <= fm_y[i-1];
      fm_ovf[i] <= fm_ovf[i-1];
    end
  end
  assign fmul_y   = fm_y[NSTAGE-1];
  assign fmul_ovf = fm_ovf[NSTAGE-1];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d;
  logic [W-1:0] cur;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (out_valid) begin
        cur = {out_tag, out_y, out_ovf};
        if (hold_v) check("hold_stable", cur, hold_d);
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
          else check("pop_data", cur, exp_q.pop_front());
          pop_cyc_q.push_back(cyc);
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_d = cur;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (dut.push && dut.u_fifo.count == DEPTH && !dut.pop) check("push_into_full", 1, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_issue(input logic v, input logic [TAGW-1:0] tag, input logic [31:0] y,
                             input logic o, output logic acc);
    issue_valid = v;
    issue_tag   = tag;
    op_y        = y;
    op_ovf      = o;
    @(negedge clk);
    acc = v && issue_ready;
    if (acc) exp_q.push_back({tag, y, o});
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- global bound ----------------
  initial begin
    #100000;
    n_fail++;
    $display("FAIL global_timeout: got no finish, expected finish by 100000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       acc;
    logic [5:0] acc_vec;
    int         c;
    int         n_acc;
    int         seen;

    rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; op_y = '0; op_ovf = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;

    // reset values
    tick(2);
    @(negedge clk);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ovf_sticky", ovf_sticky, 0);
    check("rst_out_payload", {out_tag, out_y, out_ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);

    // single issue: 1.0 * 2.0, tag 3
    out_ready = 1'b1;
    pop_cyc_q.delete();
    c = cyc;
    drive_issue(1'b1, 5'd3, 32'h40000000, 1'b0, acc);
    check("single_accept", acc, 1);
    wait_drain("single_drain");
    check("single_latency", pop_cyc_q.size() > 0 ? pop_cyc_q[0] : -1, c + NSTAGE + 1);

    // backpressure: six back-to-back issues, only DEPTH accepted
    tick(2);
    out_ready = 1'b0;
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      drive_issue(1'b1, TAGW'(i), vec_y[i], 1'b0, acc);
      acc_vec[i] = acc;
    end
    check("bp_accept_mask", acc_vec, 6'b001111);
    @(negedge clk);
    check("bp_count_full", dut.u_fifo.count, DEPTH);
    check("bp_ready_low", issue_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_first_pop", issue_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after_pop", issue_ready, 1);
    @(posedge clk); #1;
    wait_drain("bp_drain");

    // streaming: tags 0..9 back to back, results on consecutive cycles
    tick(2);
    pop_cyc_q.delete();
    c = cyc;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive_issue(1'b1, TAGW'(i), vec_y[i % 8], 1'b0, acc);
      if (acc) n_acc++;
    end
    check("stream_accepts", n_acc, 10);
    wait_drain("stream_drain");
    check("stream_pops", pop_cyc_q.size(), 10);
    for (int i = 0; i < 10 && i < pop_cyc_q.size(); i++)
      check("stream_pop_cycle", pop_cyc_q[i], c + NSTAGE + 1 + i);

    // overflow: 0x7F000000 * 0x7F000000 saturates to +inf with ovf set
    tick(2);
    drive_issue(1'b1, 5'd7, 32'h7F800000, 1'b1, acc);
    check("ovf_accept", acc, 1);
    wait_drain("ovf_drain");
    @(negedge clk);
    check("ovf_sticky_set", ovf_sticky, STICKY_EN);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_sticky_clr", ovf_sticky, 0);
    @(posedge clk); #1;

    // reset while two multiplies are in flight
    tick(2);
    issue_valid = 1'b1; issue_tag = 5'd9;  op_y = vec_y[0]; op_ovf = 1'b0;
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_tag = 5'd10; op_y = vec_y[1];
    rst = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    check("midrst_issue_ready", issue_ready, 1);
    @(posedge clk); #1;

    // fill to DEPTH, then stream with continuous issue and pop
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive_issue(1'b1, TAGW'(16 + i), vec_y[i + 4], 1'b0, acc);
    tick(3);
    @(negedge clk);
    check("full_count", dut.u_fifo.count, DEPTH);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive_issue(1'b1, TAGW'(20 + i), vec_y[i % 8], 1'b0, acc);
      if (acc) n_acc++;
    end
    check("full_stream_accepts", n_acc, 11);
    wait_drain("full_stream_drain");

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
